// File: rtl/mpsoc_ps_ocm_model.sv
// PS stand-in for the base MPSoC platform: command port into a modelled OCM
// and LED register, plus POR / FPGA soft-reset generation toward the PL.
module mpsoc_ps_ocm_model #(
   parameter logic [31:0] OCM_BASE    = 32'hFFFC0000,
   parameter int          OCM_WORDS   = 1024,
   parameter logic [31:0] LED_ADDR    = 32'hA0000000,
   parameter int          NUM_PL_RST  = 4,
   parameter int          RST_STRETCH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  por_srstb,
   input  logic [NUM_PL_RST-1:0] fpga_soft_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [31:0]           cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [2:0]            cmd_size,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [NUM_PL_RST-1:0] pl_resetn,
   output logic [3:0]            leds
);

   localparam int          AW        = $clog2(OCM_WORDS);
   localparam int          CW        = $clog2(RST_STRETCH + 1);
   localparam logic [31:0] OCM_BYTES = 32'(4 * OCM_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state, state_nx;

   logic          fsm_rst;
   logic          accept;
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    size_q;
   logic [1:0]    lane;
   logic [31:0]   ocm_off;
   logic          ocm_hit;
   logic          led_hit;
   logic          size_ok;
   logic          err;
   logic [3:0]    be;
   logic [31:0]   wsh;
   logic [AW-1:0] idx;
   logic          mem_en;
   logic [31:0]   mem_q;
   logic [31:0]   sh;
   logic [31:0]   rd_fmt;

   logic [31:0]   mem [OCM_WORDS];

   assign fsm_rst = ~ARESETn | ~por_srstb;
   assign accept  = (state == IDLE) & cmd_valid & cmd_ready;

   always_ff @(posedge ACLK) begin
      if (accept) begin
         wr_q    <= cmd_write;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         size_q  <= cmd_size;
      end
   end

   assign lane    = addr_q[1:0];
   assign ocm_off = addr_q - OCM_BASE;
   assign ocm_hit = (addr_q >= OCM_BASE) && (ocm_off < OCM_BYTES);
   assign led_hit = addr_q[31:2] == LED_ADDR[31:2];
   assign idx     = ocm_off[AW+1:2];
   assign wsh     = wdata_q << {lane, 3'b000};

   always_comb begin
      size_ok = 1'b0;
      be      = 4'b0000;
      unique case (size_q)
         3'd1: begin
            size_ok = 1'b1;
            be      = 4'b0001 << lane;
         end
         3'd2: begin
            size_ok = ~lane[0];
            be      = 4'b0011 << lane;
         end
         3'd4: begin
            size_ok = lane == 2'd0;
            be      = 4'b1111;
         end
         default: ;
      endcase
   end

   assign err    = ~size_ok | ~(ocm_hit | led_hit);
   assign mem_en = (state == ACCESS) & ~fsm_rst & ocm_hit & ~err;

   // The read also runs on writes; its result is simply not returned.
   always_ff @(posedge ACLK) begin
      if (mem_en) begin
         if (wr_q) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
            end
         end
         mem_q <= mem[idx];
      end
   end

   always_comb begin
      rd_fmt = 32'h0;
      sh     = mem_q >> {lane, 3'b000};
      if (!err && !wr_q) begin
         if (ocm_hit) begin
            unique case (size_q)
               3'd1:    rd_fmt = {24'h0, sh[7:0]};
               3'd2:    rd_fmt = {16'h0, sh[15:0]};
               default: rd_fmt = sh;
            endcase
         end else begin
            rd_fmt = {28'h0, leds};
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (fsm_rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         cmd_ready <= state_nx == IDLE;
         rsp_valid <= state == RESP;
         rsp_rdata <= (state == RESP) ? rd_fmt : 32'h0;
         rsp_err   <= (state == RESP) & err;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         leds <= 4'h0;
      end else if (state == ACCESS && por_srstb && led_hit && !ocm_hit
                   && wr_q && !err) begin
         leds <= wdata_q[3:0];
      end
   end

   logic [NUM_PL_RST-1:0] req;
   logic [CW-1:0]         cnt [NUM_PL_RST];

   assign req = fpga_soft_rst | {NUM_PL_RST{~por_srstb}};

   // Counter reload on every request cycle stretches short pulses.
   always_ff @(posedge ACLK) begin
      for (int i = 0; i < NUM_PL_RST; i++) begin
         if (!ARESETn || req[i]) begin
            cnt[i] <= CW'(RST_STRETCH);
         end else if (cnt[i] != '0) begin
            cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PL_RST; i++) begin
         pl_resetn[i] = ~req[i] & (cnt[i] == '0);
      end
   end

endmodule

// File: tb/tb_mpsoc_ps_ocm_model.sv
// Directed bench for mpsoc_ps_ocm_model: scoreboarded command responses,
// PL reset stretching, POR drop behaviour and LED register.
module tb_mpsoc_ps_ocm_model;

   logic        tb_ACLK;
   logic        ARESETn;
   logic        por_srstb;
   logic [3:0]  fpga_soft_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [3:0]  pl_resetn;
   logic [3:0]  leds;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   mpsoc_ps_ocm_model dut (
      .ACLK          (tb_ACLK),
      .ARESETn       (ARESETn),
      .por_srstb     (por_srstb),
      .fpga_soft_rst (fpga_soft_rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_size      (cmd_size),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .pl_resetn     (pl_resetn),
      .leds          (leds)
   );

   initial tb_ACLK = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_cmd(input string tag, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input logic [31:0] erd,
                         input logic eerr);
      int   lat;
      exp_t e;
      wait_ready();
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_size  = size;
      cmd_valid = 1'b1;
      sb_q.push_back('{rdata: erd, err: eerr});
      step();
      cmd_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 8) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      step();
      chk({tag, "_strobe"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int lowcnt;
      int hicnt;
      ARESETn       = 1'b0;
      por_srstb     = 1'b1;
      fpga_soft_rst = 4'h0;
      cmd_valid     = 1'b0;
      cmd_write     = 1'b0;
      cmd_addr      = 32'h0;
      cmd_wdata     = 32'h0;
      cmd_size      = 3'd0;

      for (int i = 0; i < 20; i++) step();
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_pl", 32'(pl_resetn), 32'h0);

      ARESETn = 1'b1;
      #1;
      lowcnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (pl_resetn !== 4'hF) lowcnt++;
         if (i == 0) chk("ready_at_release", 32'(cmd_ready), 32'd0);
         if (i == 1) chk("ready_after_release", 32'(cmd_ready), 32'd1);
         step();
      end
      chk("pl_low_after_reset", 32'(lowcnt), 32'd16);
      chk("pl_released", 32'(pl_resetn), 32'hF);
      chk("leds_after_reset", 32'(leds), 32'h0);

      do_cmd("wr_word", 1'b1, 32'hFFFC0000, 32'hDEADBEEF, 3'd4, 32'h0, 1'b0);
      do_cmd("rd_word", 1'b0, 32'hFFFC0000, 32'h0, 3'd4, 32'hDEADBEEF, 1'b0);
      do_cmd("wr_byte", 1'b1, 32'hFFFC0002, 32'h00000055, 3'd1, 32'h0, 1'b0);
      do_cmd("rd_merge", 1'b0, 32'hFFFC0000, 32'h0, 3'd4, 32'hDE55BEEF, 1'b0);
      do_cmd("rd_half", 1'b0, 32'hFFFC0002, 32'h0, 3'd2, 32'h0000DE55, 1'b0);
      do_cmd("rd_byte1", 1'b0, 32'hFFFC0001, 32'h0, 3'd1, 32'h000000BE, 1'b0);
      do_cmd("rd_half_odd", 1'b0, 32'hFFFC0001, 32'h0, 3'd2, 32'h0, 1'b1);
      do_cmd("rd_unmapped", 1'b0, 32'h00001000, 32'h0, 3'd4, 32'h0, 1'b1);
      do_cmd("wr_misalign", 1'b1, 32'hFFFC0002, 32'h12345678, 3'd4, 32'h0, 1'b1);
      do_cmd("wr_size3", 1'b1, 32'hFFFC0000, 32'h11111111, 3'd3, 32'h0, 1'b1);
      do_cmd("rd_unchanged", 1'b0, 32'hFFFC0000, 32'h0, 3'd4, 32'hDE55BEEF, 1'b0);

      do_cmd("wr_top", 1'b1, 32'hFFFC0FFC, 32'hCAFEF00D, 3'd4, 32'h0, 1'b0);
      do_cmd("wr_top_half", 1'b1, 32'hFFFC0FFE, 32'h0000ABCD, 3'd2, 32'h0, 1'b0);
      do_cmd("rd_top", 1'b0, 32'hFFFC0FFC, 32'h0, 3'd4, 32'hABCDF00D, 1'b0);
      do_cmd("rd_past_end", 1'b0, 32'hFFFC1000, 32'h0, 3'd4, 32'h0, 1'b1);
      do_cmd("rd_below", 1'b0, 32'hFFFBFFFC, 32'h0, 3'd4, 32'h0, 1'b1);

      do_cmd("wr_led", 1'b1, 32'hA0000000, 32'h0000000A, 3'd4, 32'h0, 1'b0);
      chk("leds_written", 32'(leds), 32'hA);
      do_cmd("rd_led", 1'b0, 32'hA0000000, 32'h0, 3'd4, 32'h0000000A, 1'b0);
      do_cmd("wr_led_bad", 1'b1, 32'hA0000004, 32'h00000003, 3'd4, 32'h0, 1'b1);
      chk("leds_kept", 32'(leds), 32'hA);

      step();
      lowcnt = 0;
      hicnt  = 0;
      for (int i = 0; i < 30; i++) begin
         fpga_soft_rst = (i < 3) ? 4'h1 : 4'h0;
         #1;
         if (pl_resetn[0] !== 1'b1) lowcnt++;
         if (pl_resetn[3:1] !== 3'b111) hicnt++;
         step();
      end
      chk("soft_rst_low", 32'(lowcnt), 32'd19);
      chk("soft_rst_others", 32'(hicnt), 32'd0);

      wait_ready();
      cmd_write = 1'b0;
      cmd_addr  = 32'hFFFC0000;
      cmd_size  = 3'd4;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      por_srstb = 1'b0;
      hicnt = 0;
      lowcnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp_valid !== 1'b0) hicnt++;
         if (cmd_ready !== 1'b0) lowcnt++;
      end
      chk("por_pl_low", 32'(pl_resetn), 32'h0);
      por_srstb = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_valid !== 1'b0) hicnt++;
      end
      chk("por_no_response", 32'(hicnt), 32'd0);
      chk("por_ready_low", 32'(lowcnt), 32'd0);
      chk("por_leds_kept", 32'(leds), 32'hA);
      chk("por_pl_stretch", 32'(pl_resetn), 32'h0);
      do_cmd("rd_after_por", 1'b0, 32'hFFFC0000, 32'h0, 3'd4, 32'hDE55BEEF, 1'b0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      for (int i = 0; i < 20; i++) step();
      chk("pl_after_por", 32'(pl_resetn), 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
